// File: rtl/membridge_arbiter_if.sv
// Request/grant and bridge-control bundle between the two requesters, the
// arbiter and the memory bridge drivers.
interface membridge_arbiter_if;
    logic cpu_req;
    logic cpu_write;
    logic cpu_gnt;
    logic dma_req;
    logic dma_write;
    logic dma_gnt;
    logic MemBridge_Assert;
    logic MemBridge_Direction;
    logic bridge_busy;
    logic owner;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_write, dma_req, dma_write,
        output cpu_gnt, dma_gnt, MemBridge_Assert, MemBridge_Direction,
               bridge_busy, owner
    );

    // Requester / observer side
    modport master (
        output cpu_req, cpu_write, dma_req, dma_write,
        input  cpu_gnt, dma_gnt, MemBridge_Assert, MemBridge_Direction,
               bridge_busy, owner
    );
endinterface

// File: rtl/membridge_arbiter.sv
// Sequencer/arbiter for the main-bus <-> memory-data bridge.
// Shares the bridge between the CPU memory stage and the DMA engine, holds
// each access for ACCESS_CYCLES cycles, pulses the winner's gnt in the last
// Assert cycle and lets DMA win after DMA_MAX_WAIT consecutive CPU transfers.
// Optional feature: define MEMBRIDGE_TURNAROUND_EN to insert a one-cycle
// TURN state (Assert low) on every direction change.
module membridge_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned DMA_MAX_WAIT  = 4
) (
    input  logic               clk,
    input  logic               reset,
    membridge_arbiter_if.slave bus
);

    localparam int unsigned     CntW     = 4;
    localparam logic [CntW-1:0] LastBeat = CntW'(ACCESS_CYCLES - 1);
    localparam logic [CntW-1:0] MaxWait  = CntW'(DMA_MAX_WAIT);
`ifdef MEMBRIDGE_TURNAROUND_EN
    localparam bit TurnEn = 1'b1;
`else
    localparam bit TurnEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [CntW-1:0] beatCnt;
    logic [CntW-1:0] beatNext;
    logic [CntW-1:0] starveCnt;
    logic            cpuReqQ;
    logic            dmaReqQ;
    logic            ownerQ;
    logic            ownerNext;
    logic            dirQ;
    logic            dirNext;
    logic            assertQ;
    logic            assertNext;
    logic            cpuGntQ;
    logic            cpuGntNext;
    logic            dmaGntQ;
    logic            dmaGntNext;
    logic            busyQ;
    logic            busyNext;
    logic            cpuCand;
    logic            dmaCand;
    logic            arbNow;
    logic            winDma;
    logic            winWrite;

    // Requests seen by arbitration: registered copies in IDLE (launch latency), live at a transfer's end
    assign cpuCand  = (state == IDLE) ? cpuReqQ : bus.cpu_req;
    assign dmaCand  = (state == IDLE) ? dmaReqQ : bus.dma_req;
    assign arbNow   = (state == IDLE) || ((state == XFER) && (beatCnt == LastBeat));
    assign winDma   = !cpuCand || (dmaCand && (starveCnt == MaxWait));
    assign winWrite = winDma ? bus.dma_write : bus.cpu_write;

    // State register, latched transfer attributes, starvation counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beatCnt   <= '0;
            starveCnt <= '0;
            cpuReqQ   <= 1'b0;
            dmaReqQ   <= 1'b0;
            ownerQ    <= 1'b0;
            dirQ      <= 1'b0;
            assertQ   <= 1'b0;
            cpuGntQ   <= 1'b0;
            dmaGntQ   <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            state   <= stateNext;
            beatCnt <= beatNext;
            cpuReqQ <= bus.cpu_req;
            dmaReqQ <= bus.dma_req;
            ownerQ  <= ownerNext;
            dirQ    <= dirNext;
            assertQ <= assertNext;
            cpuGntQ <= cpuGntNext;
            dmaGntQ <= dmaGntNext;
            busyQ   <= busyNext;
            if (!bus.dma_req || dmaGntNext) begin
                starveCnt <= '0;
            end else if (cpuGntNext && (starveCnt < MaxWait)) begin
                starveCnt <= starveCnt + CntW'(1);
            end
        end
    end

    // Next-state: beat counting, then arbitration in IDLE and in the final beat
    always_comb begin
        stateNext = state;
        beatNext  = beatCnt;
        ownerNext = ownerQ;
        dirNext   = dirQ;
        case (state)
            TURN: begin
                stateNext = XFER;
                beatNext  = '0;
            end
            XFER: begin
                if (beatCnt != LastBeat) begin
                    beatNext = beatCnt + CntW'(1);
                end
            end
            default: begin
            end
        endcase
        if (arbNow) begin
            if (cpuCand || dmaCand) begin
                ownerNext = winDma;
                dirNext   = winWrite;
                beatNext  = '0;
                stateNext = (TurnEn && (winWrite != dirQ)) ? TURN : XFER;
            end else begin
                stateNext = IDLE;
            end
        end
    end

    // Output decode from the next state so the registered outputs line up with the state
    always_comb begin
        assertNext = (stateNext == XFER);
        busyNext   = (stateNext != IDLE);
        cpuGntNext = (stateNext == XFER) && (beatNext == LastBeat) && !ownerNext;
        dmaGntNext = (stateNext == XFER) && (beatNext == LastBeat) && ownerNext;
    end

    assign bus.MemBridge_Assert    = assertQ;
    assign bus.MemBridge_Direction = dirQ;
    assign bus.cpu_gnt             = cpuGntQ;
    assign bus.dma_gnt             = dmaGntQ;
    assign bus.bridge_busy         = busyQ;
    assign bus.owner               = ownerQ;

endmodule
